fifo_wr_arbiter: RTL and testbench

//   Shares the single FIFO write port (write unit + memory, wr_clk domain) among N requesters.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// A grant lasts up to BURST beats, ends early when its owner drops req, and stalls while the FIFO is full.

module fifo_wr_arbiter_lane #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic         req,
  input  logic         wr_en,
  input  logic [W-1:0] data,
  output logic         hit,
  output logic         ack,
  output logic [W-1:0] data_sel
);
  assign hit      = sel & req;
  assign ack      = sel & wr_en;
  assign data_sel = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 4,
  localparam int OW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic           wr_clk,
  input  logic           wr_rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  input  logic           o_fifo_full,
  output logic [N-1:0]   ack,
  output logic           wr_en,
  output logic [W-1:0]   wr_data,
  output logic [OW-1:0]  owner,
  output logic           busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [OW-1:0]       owner_nxt, rr_ptr, rr_nxt, pick;
  logic [3:0]          beat_cnt, cnt_nxt;
  logic                found;
  logic [N-1:0]        sel, hit;
  logic [N-1:0][W-1:0] dsel;

  assign busy  = (state == GRANT);
  assign wr_en = busy & (|hit) & ~o_fifo_full;

  // sel is all-zero outside GRANT, so ack and wr_data are zero in IDLE and during reset
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign sel[k] = busy && (owner == OW'(k));
    fifo_wr_arbiter_lane #(.W(W)) u_lane (
      .sel      (sel[k]),
      .req      (req[k]),
      .wr_en    (wr_en),
      .data     (req_data[k*W +: W]),
      .hit      (hit[k]),
      .ack      (ack[k]),
      .data_sel (dsel[k])
    );
  end

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < N; k++) wr_data = wr_data | dsel[k];
  end

  // First requester at or after rr_ptr, wrapping N-1 -> 0
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!(|hit) || (wr_en && beat_cnt == 4'(BURST-1))) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rr_nxt    = (owner == OW'(N-1)) ? '0 : OW'(owner + 1'b1);
        end else if (wr_en) begin
          cnt_nxt = beat_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, W=8, BURST=4); each cycle compares
// the packed tuple {busy, owner-if-busy, wr_en, ack, wr_data} with a hand-built value.

module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, BURST = 4, OW = 2;

  logic           wr_clk = 1'b0;
  logic           wr_rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           o_fifo_full;
  logic [N-1:0]   ack;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [OW-1:0]  owner;
  logic           busy;

  int chks  = 0;
  int fails = 0;

  fifo_wr_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .req         (req),
    .req_data    (req_data),
    .o_fifo_full (o_fifo_full),
    .ack         (ack),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .owner       (owner),
    .busy        (busy)
  );

  always #5 wr_clk = ~wr_clk;

  // owner is only meaningful while busy, so it is masked to 0 otherwise
  logic [15:0] obs;
  assign obs = {busy, busy ? owner : 2'd0, wr_en, ack, wr_data};

  localparam logic [7:0] D0 = 8'h0A, D1 = 8'h1B, D2 = 8'h2C, D3 = 8'h3D;
  localparam logic [15:0] IDLE_V = 16'h0000;

  function automatic logic [7:0] dat(input int o);
    case (o)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  // expected tuple while busy: beat written (we=1) or not
  function automatic logic [15:0] ex(input int o, input bit we);
    logic [3:0] a;
    a = we ? (4'b0001 << o) : 4'b0000;
    return {1'b1, 2'(o), we, a, dat(o)};
  endfunction

  task automatic start(input logic [3:0] r);
    wr_rst_n    = 1'b0;
    o_fifo_full = 1'b0;
    req         = r;
    req_data    = {D3, D2, D1, D0};
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    wr_rst_n    = 1'b0;
    o_fifo_full = 1'b0;
    req         = 4'b1111;
    req_data    = {D3, D2, D1, D0};
    #1;
    chks++;
    if (obs !== IDLE_V) begin fails++; $display("FAIL reset_hold got %h want %h", obs, IDLE_V); end
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    #1;
    chks++;
    if (obs !== IDLE_V) begin fails++; $display("FAIL reset_idle got %h want %h", obs, IDLE_V); end
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(0, 1)) begin fails++; $display("FAIL reset_first_grant got %h want %h", obs, ex(0, 1)); end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    start(4'b1111);
    for (int g = 0; g < 5; g++) begin
      chks++;
      if (obs !== IDLE_V) begin fails++; $display("FAIL rr_bubble g%0d got %h want %h", g, obs, IDLE_V); end
      for (int b = 0; b < BURST; b++) begin
        @(negedge wr_clk); #1;
        chks++;
        if (obs !== ex(seq[g], 1)) begin
          fails++; $display("FAIL rr_beat g%0d b%0d got %h want %h", g, b, obs, ex(seq[g], 1));
        end
      end
      @(negedge wr_clk); #1;
    end
  endtask

  task automatic test_early_drop();
    start(4'b0110);
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(1, 1)) begin fails++; $display("FAIL drop_beat1 got %h want %h", obs, ex(1, 1)); end
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(1, 1)) begin fails++; $display("FAIL drop_beat2 got %h want %h", obs, ex(1, 1)); end
    @(negedge wr_clk);
    req = 4'b0100;
    #1;
    chks++;
    if (obs !== ex(1, 0)) begin fails++; $display("FAIL drop_release got %h want %h", obs, ex(1, 0)); end
    @(negedge wr_clk);
    req = 4'b0110;  // requester 1 returns, but rr_ptr=2 must favour 2
    #1;
    chks++;
    if (obs !== IDLE_V) begin fails++; $display("FAIL drop_bubble got %h want %h", obs, IDLE_V); end
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(2, 1)) begin fails++; $display("FAIL drop_next_owner got %h want %h", obs, ex(2, 1)); end
  endtask

  task automatic test_full_stall();
    int acks = 0;
    start(4'b0001);
    for (int b = 0; b < 2; b++) begin
      @(negedge wr_clk); #1;
      chks++;
      if (obs !== ex(0, 1)) begin fails++; $display("FAIL stall_pre b%0d got %h want %h", b, obs, ex(0, 1)); end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge wr_clk);
      o_fifo_full = 1'b1;
      #1;
      chks++;
      if (obs !== ex(0, 0)) begin fails++; $display("FAIL stall_hold c%0d got %h want %h", c, obs, ex(0, 0)); end
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge wr_clk);
      o_fifo_full = 1'b0;
      #1;
      if (ack == 4'b0001) acks++;
      chks++;
      if (obs !== ex(0, 1)) begin fails++; $display("FAIL stall_post b%0d got %h want %h", b, obs, ex(0, 1)); end
    end
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== IDLE_V) begin fails++; $display("FAIL stall_release got %h want %h", obs, IDLE_V); end
    chks++;
    if (acks !== 2) begin fails++; $display("FAIL stall_resumed_beats got %0d want 2", acks); end
  endtask

  task automatic test_wrap_sparse();
    int seq [2] = '{3, 0};
    logic stray = 1'b0;
    start(4'b0100);
    for (int b = 0; b < BURST; b++) begin
      @(negedge wr_clk); #1;
      chks++;
      if (obs !== ex(2, 1)) begin fails++; $display("FAIL wrap_setup b%0d got %h want %h", b, obs, ex(2, 1)); end
    end
    @(negedge wr_clk);
    req = 4'b1001;
    #1;
    for (int g = 0; g < 2; g++) begin
      chks++;
      if (obs !== IDLE_V) begin fails++; $display("FAIL wrap_bubble g%0d got %h want %h", g, obs, IDLE_V); end
      for (int b = 0; b < BURST; b++) begin
        @(negedge wr_clk); #1;
        stray = stray | ack[1] | ack[2];
        chks++;
        if (obs !== ex(seq[g], 1)) begin
          fails++; $display("FAIL wrap_beat g%0d b%0d got %h want %h", g, b, obs, ex(seq[g], 1));
        end
      end
      @(negedge wr_clk); #1;
    end
    chks++;
    if (stray !== 1'b0) begin fails++; $display("FAIL wrap_stray_ack got %b want 0", stray); end
  endtask

  task automatic test_reset_mid_burst();
    start(4'b0010);
    @(negedge wr_clk); #1;
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(1, 1)) begin fails++; $display("FAIL rstmid_beat2 got %h want %h", obs, ex(1, 1)); end
    wr_rst_n = 1'b0;
    #1;
    chks++;
    if ({obs, owner} !== {IDLE_V, 2'd0}) begin
      fails++; $display("FAIL rstmid_async got %h/%0d want %h/0", obs, owner, IDLE_V);
    end
    @(negedge wr_clk);
    req      = 4'b1111;
    wr_rst_n = 1'b1;
    #1;
    chks++;
    if (obs !== IDLE_V) begin fails++; $display("FAIL rstmid_idle got %h want %h", obs, IDLE_V); end
    @(negedge wr_clk); #1;
    chks++;
    if (obs !== ex(0, 1)) begin fails++; $display("FAIL rstmid_regrant got %h want %h", obs, ex(0, 1)); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_drop();
    test_full_stall();
    test_wrap_sparse();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", chks - fails, chks);
    $finish;
  end

  // invariants checked every cycle away from the edge
  always @(negedge wr_clk) begin
    if (wr_rst_n === 1'b1) begin
      if (wr_en && o_fifo_full) begin
        fails++; chks++; $display("FAIL overflow wr_en=%b full=%b want wr_en 0", wr_en, o_fifo_full);
      end
      if (!$onehot0(ack)) begin
        fails++; chks++; $display("FAIL ack_onehot got %b want at most one bit", ack);
      end
    end
  end
endmodule
